dual_port_ram_be_pipe: RTL and testbench



---
 rtl/ram_defs.sv | 13 +
 rtl/ram_byte_merge.sv | 29 ++
 rtl/dual_port_ram_be_pipe.sv | 129 ++++++++++++
 tb/tb_dual_port_ram_be_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_defs.sv
// Shared constants and width helpers for the byte-enabled dual-port RAM.
package ram_defs;

    // Same-address read-during-write policies
    localparam int RDW_OLD_DATA = 0;
    localparam int RDW_NEW_DATA = 1;

    // Number of byte-enable lanes in a word
    function automatic int nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Lane-wise merge of two words: each lane comes from new_data when its
// select bit is set, otherwise from old_data.
module ram_byte_merge
    import ram_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] sel,
    input  logic [DATA_WIDTH-1:0]                 old_data,
    input  logic [DATA_WIDTH-1:0]                 new_data,
    output logic [DATA_WIDTH-1:0]                 merged
);

    localparam int NB = nb(DATA_WIDTH, BYTE_WIDTH);

    // Pick each lane from the new or the old word
    always_comb begin
        merged = old_data;
        for (int i = 0; i < NB; i++) begin
            if (sel[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = old_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_be_pipe.sv
// Simple dual-port RAM with per-byte write enables, a 1- or 2-cycle read
// pipeline with valid pulse, and a selectable same-address read-during-write
// policy (old data, or new data merged lane-by-lane before the output stage).
module dual_port_ram_be_pipe
    import ram_defs::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  we,
    input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] be,
    input  logic [ADDR_WIDTH-1:0]                 w_addr,
    input  logic [DATA_WIDTH-1:0]                 d,
    input  logic                                  re,
    input  logic [ADDR_WIDTH-1:0]                 r_addr,
    output logic [DATA_WIDTH-1:0]                 q,
    output logic                                  q_valid
);

    localparam int NB         = nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    // Clamp keeps the arrays legal even when the parameter check below fires
    localparam int PIPE_DEPTH = (READ_LATENCY == 2) ? 2 : 1;

    // Elaboration-time parameter checks
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if ((RDW_MODE != RDW_OLD_DATA) && (RDW_MODE != RDW_NEW_DATA)) begin : g_bad_rdw
        $error("RDW_MODE must be 0 or 1");
    end

    // Storage is deliberately not reset so it maps onto block RAM
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_vld_r;
    logic                  hit_r;
    logic [NB-1:0]         hit_be_r;
    logic [DATA_WIDTH-1:0] hit_d_r;

    logic [NB-1:0]         merge_sel_s;
    logic [DATA_WIDTH-1:0] merged_s;

    logic [DATA_WIDTH-1:0] pipe_r [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] vld_r;

    // Write port: update only the enabled lanes; writes are ignored in reset
    always_ff @(posedge clk) begin
        if (we && reset_n) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem_r[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= d[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 1: registered array read plus capture of a same-address write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
            rd_vld_r  <= 1'b0;
            hit_r     <= 1'b0;
            hit_be_r  <= {NB{1'b0}};
            hit_d_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_vld_r <= re;
            if (re) begin
                rd_data_r <= mem_r[r_addr];
                hit_r     <= we && (w_addr == r_addr);
                hit_be_r  <= be;
                hit_d_r   <= d;
            end
        end
    end

    // Forwarding lanes are only selected in new-data mode on an address hit
    always_comb begin
        if ((RDW_MODE == RDW_NEW_DATA) && hit_r) begin
            merge_sel_s = hit_be_r;
        end else begin
            merge_sel_s = {NB{1'b0}};
        end
    end

    ram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_merge (
        .sel      (merge_sel_s),
        .old_data (rd_data_r),
        .new_data (hit_d_r),
        .merged   (merged_s)
    );

    // Output pipeline: data advances only with its valid, so q holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_r[i] <= {DATA_WIDTH{1'b0}};
            end
            vld_r <= {PIPE_DEPTH{1'b0}};
        end else begin
            vld_r[0] <= rd_vld_r;
            if (rd_vld_r) begin
                pipe_r[0] <= merged_s;
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end
    end

    assign q       = pipe_r[PIPE_DEPTH-1];
    assign q_valid = vld_r[PIPE_DEPTH-1];

endmodule

// File: tb/tb_dual_port_ram_be_pipe.sv
// Scoreboard bench: four instances (latency 1/2 x old/new data) share one
// stimulus stream; each read pushes the expected word and arrival cycle per
// instance, and a single monitor pops and compares on every q_valid.
module tb_dual_port_ram_be_pipe;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  w_addr;
    logic [31:0] d;
    logic        re;
    logic [9:0]  r_addr;

    logic [31:0] q_w  [4];
    logic        qv_w [4];

    exp_t        exp_q [4][$];
    logic [31:0] mem_m [1024];
    logic [31:0] last_q [4];
    int          cnt;
    int          n_chk;
    int          n_fail;
    logic        do_final;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dual_port_ram_be_pipe #(
            .DATA_WIDTH   (32),
            .BYTE_WIDTH   (8),
            .ADDR_WIDTH   (10),
            .READ_LATENCY ((g < 2) ? 1 : 2),
            .RDW_MODE     (g % 2)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (we),
            .be      (be),
            .w_addr  (w_addr),
            .d       (d),
            .re      (re),
            .r_addr  (r_addr),
            .q       (q_w[g]),
            .q_valid (qv_w[g])
        );
    end

    function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    // Monitor: reset values, scoreboard pops on q_valid, hold of q otherwise
    always @(negedge clk) begin
        cnt = cnt + 1;
        for (int k = 0; k < 4; k++) begin
            n_chk = n_chk + 1;
            if (!reset_n) begin
                if (q_w[k] !== 32'h0 || qv_w[k] !== 1'b0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL reset inst%0d: q=%h q_valid=%b, required q=0 q_valid=0", k, q_w[k], qv_w[k]);
                end
                last_q[k] = 32'h0;
            end else if (qv_w[k]) begin
                if (exp_q[k].size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL stray_valid inst%0d: q=%h at cycle %0d, no read outstanding", k, q_w[k], cnt);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    if (q_w[k] !== e.data || cnt != e.cyc) begin
                        n_fail = n_fail + 1;
                        $display("FAIL read inst%0d: q=%h at cycle %0d, required %h at cycle %0d",
                                 k, q_w[k], cnt, e.data, e.cyc);
                    end
                end
                last_q[k] = q_w[k];
            end else begin
                if (q_w[k] !== last_q[k]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL hold inst%0d: q=%h, required held %h", k, q_w[k], last_q[k]);
                end
            end
        end
        if (do_final) begin
            for (int k = 0; k < 4; k++) begin
                n_chk = n_chk + 1;
                if (exp_q[k].size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL drain inst%0d: %0d reads outstanding, required 0", k, exp_q[k].size());
                end
            end
        end
    end

    // One cycle of stimulus; hand values replace the model when hand=1
    task automatic drive(input logic w, input logic [3:0] b, input logic [9:0] wa, input logic [31:0] dd,
                         input logic r, input logic [9:0] ra,
                         input logic hand, input logic [31:0] h0, input logic [31:0] h1);
        exp_t e;
        @(posedge clk);
        #1;
        we = w; be = b; w_addr = wa; d = dd; re = r; r_addr = ra;
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                if (hand) begin
                    e.data = (k % 2 == 1) ? h1 : h0;
                end else if ((k % 2 == 1) && w && (wa == ra)) begin
                    e.data = merge_m(mem_m[ra], dd, b);
                end else begin
                    e.data = mem_m[ra];
                end
                e.cyc = cnt + ((k < 2) ? 1 : 2) + 2;
                exp_q[k].push_back(e);
            end
        end
        if (w) mem_m[wa] = merge_m(mem_m[wa], dd, b);
    endtask

    task automatic wr(input logic [9:0] a, input logic [3:0] b, input logic [31:0] dd);
        drive(1'b1, b, a, dd, 1'b0, 10'd0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [9:0] a);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, a, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd_h(input logic [9:0] a, input logic [31:0] e0, input logic [31:0] e1);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, a, 1'b1, e0, e1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0, 1'b0, 32'h0, 32'h0);
    endtask

    // Assert reset for n cycles while hammering we/re, then release idle
    task automatic hold_reset(input int n);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        we = 1'b1; be = 4'hF; w_addr = 10'd20; d = 32'hFFFF_FFFF; re = 1'b1; r_addr = 10'd20;
        repeat (n) @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        cnt = 0; n_chk = 0; n_fail = 0; do_final = 1'b0;
        for (int k = 0; k < 4; k++) last_q[k] = 32'h0;
        reset_n = 1'b0;
        we = 1'b1; be = 4'hF; w_addr = 10'd20; d = 32'hFFFF_FFFF; re = 1'b1; r_addr = 10'd20;
        repeat (4) @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        reset_n = 1'b1;

        // Initialise the low addresses used by the random phase
        for (int i = 0; i < 16; i++) wr(10'(i), 4'hF, 32'h5A00_0000 | 32'(i));

        // Byte enables
        wr(10'd5, 4'hF, 32'h1122_3344);
        wr(10'd5, 4'b0101, 32'hAABB_CCDD);
        rd_h(10'd5, 32'h11BB_33DD, 32'h11BB_33DD);

        // Back-to-back reads, then q held
        for (int i = 0; i < 8; i++) wr(10'(i), 4'hF, 32'hA500_0000 | 32'(i));
        for (int i = 0; i < 8; i++) rd_h(10'(i), 32'hA500_0000 | 32'(i), 32'hA500_0000 | 32'(i));
        idle(5);

        // Read during write to the same address
        wr(10'd9, 4'hF, 32'hDEAD_BEEF);
        drive(1'b1, 4'b0011, 10'd9, 32'h0000_CAFE, 1'b1, 10'd9, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_CAFE);
        rd_h(10'd9, 32'hDEAD_CAFE, 32'hDEAD_CAFE);
        idle(3);

        // Address extremes and the be=0 no-op
        wr(10'd0, 4'hF, 32'h0BAD_F00D);
        wr(10'd1023, 4'hF, 32'hCAFE_1023);
        rd_h(10'd0, 32'h0BAD_F00D, 32'h0BAD_F00D);
        rd_h(10'd1023, 32'hCAFE_1023, 32'hCAFE_1023);
        wr(10'd1023, 4'h0, 32'hFFFF_FFFF);
        rd_h(10'd1023, 32'hCAFE_1023, 32'hCAFE_1023);
        idle(3);

        // Reset while a read is in flight; writes during reset must be ignored
        wr(10'd20, 4'hF, 32'h1234_5678);
        rd(10'd3);
        hold_reset(3);
        rd_h(10'd20, 32'h1234_5678, 32'h1234_5678);
        idle(3);

        // Random traffic against the model over a small address window
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 1'b0, 32'h0, 32'h0);
        end
        idle(6);

        @(posedge clk);
        #1;
        do_final = 1'b1;
        @(posedge clk);
        #1;
        do_final = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
